// File: rtl/prog_freq_div_pkg.sv
// Shared constants for the programmable frequency divider.
package prog_freq_div_pkg;

    localparam int unsigned MIN_RATIO       = 2;
    localparam int unsigned DEF_WIDTH       = 10;
    localparam int unsigned DEF_RESET_RATIO = 8;

endpackage

// File: rtl/prog_freq_div_if.sv
// Control/status bundle between a ratio requester (master) and the divider (slave).
interface prog_freq_div_if
    import prog_freq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             EN;
    logic [WIDTH-1:0] DIV_RATIO;
    logic             RATIO_LOAD;
    logic             RATIO_ACK;
    logic             DIV_OUT;
    logic             DIV_PULSE;
    logic [WIDTH-1:0] DIV_TAPS;

    modport master (
        output EN, DIV_RATIO, RATIO_LOAD,
        input  RATIO_ACK, DIV_OUT, DIV_PULSE, DIV_TAPS
    );

    modport slave (
        input  EN, DIV_RATIO, RATIO_LOAD,
        output RATIO_ACK, DIV_OUT, DIV_PULSE, DIV_TAPS
    );

endinterface

// File: rtl/prog_freq_div_ratio_ctrl.sv
// Divide-ratio handshake: captures a clamped request, applies it at a wrap (or at once while idle), acknowledges.
module prog_freq_div_ratio_ctrl
    import prog_freq_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned RESET_RATIO = DEF_RESET_RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wrap,
    input  logic             ratio_load,
    input  logic [WIDTH-1:0] div_ratio,
    output logic [WIDTH-1:0] n_act,
    output logic             apply,
    output logic             ratio_ack
);

    logic [WIDTH-1:0] pend;
    logic             pending;
    logic [WIDTH-1:0] ratio_clamped;

    always_comb begin
        ratio_clamped = div_ratio;
        if (div_ratio < WIDTH'(MIN_RATIO)) begin
            ratio_clamped = WIDTH'(MIN_RATIO);
        end
        // pending is only set after the capture edge, so a capture on a wrap edge waits for the next wrap
        apply = pending && (wrap || !en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            pending   <= 1'b0;
            n_act     <= WIDTH'(RESET_RATIO);
            ratio_ack <= 1'b0;
        end else begin
            ratio_ack <= apply;
            if (apply) begin
                n_act   <= pend;
                pending <= 1'b0;
            end else if (ratio_load && !pending) begin
                pend    <= ratio_clamped;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_freq_div.sv
// Programmable clock divider with registered divided clock, wrap strobe and optional binary taps.
// Define PROG_FREQ_DIV_TAPS_EN to build the tap counter; otherwise DIV_TAPS is tied to zero.
module prog_freq_div
    import prog_freq_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned RESET_RATIO = DEF_RESET_RATIO
) (
    input  logic            BEFORE_DIVIDER,
    input  logic            RESETB,
    prog_freq_div_if.slave  bus
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] taps;
    logic [WIDTH:0]   half;
    logic             wrap;
    logic             apply;
    logic             ratio_ack;
    logic             div_out;
    logic             div_pulse;

    prog_freq_div_ratio_ctrl #(
        .WIDTH       (WIDTH),
        .RESET_RATIO (RESET_RATIO)
    ) u_ratio_ctrl (
        .clk        (BEFORE_DIVIDER),
        .rst_n      (RESETB),
        .en         (bus.EN),
        .wrap       (wrap),
        .ratio_load (bus.RATIO_LOAD),
        .div_ratio  (bus.DIV_RATIO),
        .n_act      (n_act),
        .apply      (apply),
        .ratio_ack  (ratio_ack)
    );

    always_comb begin
        wrap     = (cnt >= n_act - 1'b1);
        cnt_next = wrap ? '0 : cnt + 1'b1;
        half     = ({1'b0, n_act} + 1'b1) >> 1;
    end

    always_ff @(posedge BEFORE_DIVIDER or negedge RESETB) begin
        if (!RESETB) begin
            cnt       <= '0;
            div_out   <= 1'b0;
            div_pulse <= 1'b0;
        end else if (bus.EN) begin
            cnt       <= cnt_next;
            div_out   <= ({1'b0, cnt_next} < half);
            div_pulse <= wrap;
        end else begin
            div_pulse <= 1'b0;
            // an idle apply restarts the period at its high phase
            if (apply) begin
                cnt     <= '0;
                div_out <= 1'b1;
            end
        end
    end

`ifdef PROG_FREQ_DIV_TAPS_EN
    always_ff @(posedge BEFORE_DIVIDER or negedge RESETB) begin
        if (!RESETB) begin
            taps <= '0;
        end else if (bus.EN) begin
            taps <= taps + 1'b1;
        end
    end
`else
    always_comb begin
        taps = '0;
    end
`endif

    assign bus.DIV_OUT   = div_out;
    assign bus.DIV_PULSE = div_pulse;
    assign bus.RATIO_ACK = ratio_ack;
    assign bus.DIV_TAPS  = taps;

endmodule

// File: tb/tb_prog_freq_div.sv
// Scoreboard bench for prog_freq_div: directed steps push expected outputs, a negedge monitor pops and compares.
module tb_prog_freq_div;
    import prog_freq_div_pkg::*;

    localparam int unsigned W = 10;

    typedef struct {
        logic         out;
        logic         pulse;
        logic         ack;
        logic [W-1:0] taps;
        int           id;
    } exp_t;

    exp_t exp_q[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int step_id  = 0;
    int exp_cnt  = 0;
    int exp_n    = 8;
    int exp_taps = 0;
    logic exp_out = 1'b0;

    always #5 clk = ~clk;

    prog_freq_div_if #(.WIDTH(W)) bus ();

    prog_freq_div #(
        .WIDTH       (W),
        .RESET_RATIO (8)
    ) dut (
        .BEFORE_DIVIDER (clk),
        .RESETB         (rst_n),
        .bus            (bus)
    );

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] taps_exp();
`ifdef PROG_FREQ_DIV_TAPS_EN
        return W'(exp_taps);
`else
        return '0;
`endif
    endfunction

    // One input cycle; 'apply' marks the edge at which the hand-planned ratio switch must land.
    task automatic step(input bit en, input bit load, input int ratio, input bit apply, input int new_n);
        exp_t e;
        bit   wrapped;
        bus.EN         = en;
        bus.RATIO_LOAD = load;
        bus.DIV_RATIO  = W'(ratio);
        @(posedge clk);
        #1;
        wrapped = 1'b0;
        if (en) begin
            wrapped = (exp_cnt == exp_n - 1);
            exp_cnt = wrapped ? 0 : exp_cnt + 1;
            if (apply) exp_n = new_n;
            exp_out  = (exp_cnt < (exp_n + 1) / 2);
            exp_taps = (exp_taps + 1) % 1024;
        end else if (apply) begin
            exp_cnt = 0;
            exp_out = 1'b1;
            exp_n   = new_n;
        end
        e.out   = exp_out;
        e.pulse = wrapped;
        e.ack   = apply;
        e.taps  = taps_exp();
        e.id    = step_id;
        step_id++;
        exp_q.push_back(e);
    endtask

    task automatic run(input int k);
        repeat (k) step(1'b1, 1'b0, 0, 1'b0, 0);
    endtask

    // Capture, 'waits' pending cycles with a junk ratio on the bus, then the apply edge.
    task automatic request(input int ratio, input int new_n, input int waits);
        step(1'b1, 1'b1, ratio, 1'b0, 0);
        repeat (waits) step(1'b1, 1'b1, 7, 1'b0, 0);
        step(1'b1, 1'b1, 7, 1'b1, new_n);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_div_out"},   int'(bus.DIV_OUT),   0);
        check({tag, "_div_pulse"}, int'(bus.DIV_PULSE), 0);
        check({tag, "_ratio_ack"}, int'(bus.RATIO_ACK), 0);
        check({tag, "_div_taps"},  int'(bus.DIV_TAPS),  0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("step%0d_div_out", e.id),   int'(bus.DIV_OUT),   int'(e.out));
            check($sformatf("step%0d_div_pulse", e.id), int'(bus.DIV_PULSE), int'(e.pulse));
            check($sformatf("step%0d_ratio_ack", e.id), int'(bus.RATIO_ACK), int'(e.ack));
            check($sformatf("step%0d_div_taps", e.id),  int'(bus.DIV_TAPS),  int'(e.taps));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.EN         = 1'b0;
        bus.RATIO_LOAD = 1'b0;
        bus.DIV_RATIO  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        // Reset ratio 8: 32 edges, pulses on edges 8/16/24/32
        run(32);

        // N=5 requested at cnt=3; apply at the 7->0 wrap, junk ratio ignored while pending
        run(3);
        request(5, 5, 3);
        run(10);

        // DIV_RATIO=0 and 1 both clamp to 2
        request(0, 2, 3);
        run(6);
        request(1, 2, 0);
        run(4);

        // Capture on a wrap edge (cnt 1->0 at N=2) applies only at the following wrap
        run(1);
        request(3, 3, 1);
        // RATIO_LOAD still high in the ACK cycle: new capture of 4
        step(1'b1, 1'b1, 4, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b1, 4);
        run(8);

        // Pending N=6 with EN=0: immediate apply, then hold, then period 6
        step(1'b1, 1'b1, 6, 1'b0, 0);
        step(1'b0, 1'b1, 6, 1'b1, 6);
        step(1'b0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 0, 1'b0, 0);
        run(12);

        // Request N=3 pending, second load ignored, then reset discards it
        step(1'b1, 1'b1, 3, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 9, 1'b0, 0);
        @(negedge clk);
        #1;
        rst_n          = 1'b0;
        bus.RATIO_LOAD = 1'b0;
        #1;
        check_reset("async");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_cnt  = 0;
        exp_n    = 8;
        exp_out  = 1'b0;
        exp_taps = 0;
        run(10);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
